// File: rtl/vga_rect_plotter.sv
// Rectangle / clear-screen drawing engine for a 160x120 VGA adapter.
// Walks the clipped rectangle in raster order, one registered pixel write per clock.
module vga_rect_plotter #(
  parameter int X_W      = 11,
  parameter int Y_W      = 11,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic [X_W-1:0]      i_x0,
  input  logic [Y_W-1:0]      i_y0,
  input  logic [X_W-1:0]      i_w,
  input  logic [Y_W-1:0]      i_h,
  input  logic [COLOUR_W-1:0] i_colour_in,
  input  logic                i_hold,
  output logic [X_W-1:0]      o_x,
  output logic [Y_W-1:0]      o_y,
  output logic [COLOUR_W-1:0] o_colour,
  output logic                o_plot,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [X_W:0] L_SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] L_SH = (Y_W+1)'(SCREEN_H);

  state_t                r_state;
  logic [X_W-1:0]        r_x0, r_cx, r_x;
  logic [Y_W-1:0]        r_y0, r_cy, r_y;
  logic [X_W:0]          r_ew;
  logic [Y_W:0]          r_eh;
  logic [COLOUR_W-1:0]   r_colour_l, r_colour;
  logic                  r_plot, r_busy, r_done;

  logic [X_W-1:0]        w_x0_sel, w_w_sel;
  logic [Y_W-1:0]        w_y0_sel, w_h_sel;
  logic [X_W:0]          w_x0_ext, w_w_ext, w_x_room, w_ew;
  logic [Y_W:0]          w_y0_ext, w_h_ext, w_y_room, w_eh;
  logic                  w_last_x, w_last_y;

  // Clipping is done one bit wider so SCREEN - origin and the min never overflow.
  assign w_x0_sel = i_clear ? '0 : i_x0;
  assign w_y0_sel = i_clear ? '0 : i_y0;
  assign w_w_sel  = i_clear ? X_W'(SCREEN_W) : i_w;
  assign w_h_sel  = i_clear ? Y_W'(SCREEN_H) : i_h;

  assign w_x0_ext = {1'b0, w_x0_sel};
  assign w_y0_ext = {1'b0, w_y0_sel};
  assign w_w_ext  = {1'b0, w_w_sel};
  assign w_h_ext  = {1'b0, w_h_sel};
  assign w_x_room = L_SW - w_x0_ext;
  assign w_y_room = L_SH - w_y0_ext;

  assign w_ew = (w_x0_ext >= L_SW) ? '0 : ((w_w_ext < w_x_room) ? w_w_ext : w_x_room);
  assign w_eh = (w_y0_ext >= L_SH) ? '0 : ((w_h_ext < w_y_room) ? w_h_ext : w_y_room);

  assign w_last_x = ({1'b0, r_cx} == (r_ew - 1'b1));
  assign w_last_y = ({1'b0, r_cy} == (r_eh - 1'b1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_ew       <= '0;
      r_eh       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_colour_l <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // busy still set here means this is the done cycle; start is not taken yet
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (i_start) begin
            r_x0       <= w_x0_sel;
            r_y0       <= w_y0_sel;
            r_ew       <= w_ew;
            r_eh       <= w_eh;
            r_cx       <= '0;
            r_cy       <= '0;
            r_colour_l <= i_colour_in;
            r_busy     <= 1'b1;
            if (w_ew == '0 || w_eh == '0) r_state <= S_DONE;
            else                          r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (i_hold) begin
            r_plot <= 1'b0;
          end else begin
            r_x      <= r_x0 + r_cx;
            r_y      <= r_y0 + r_cy;
            r_colour <= r_colour_l;
            r_plot   <= 1'b1;
            if (w_last_x) begin
              r_cx <= '0;
              if (w_last_y) r_state <= S_DONE;
              else          r_cy    <= r_cy + 1'b1;
            end else begin
              r_cx <= r_cx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
